// File: rtl/jstk_spi_responder_if.sv
// SPI bus bundle between the joystick master and the responder.
// Mode 0, MSB first, ss active-low, sclk idles low.
interface jstk_spi_responder_if;
  logic ss;
  logic sclk;
  logic mosi;
  logic miso;

  modport master (output ss, output sclk, output mosi, input miso);
  modport slave  (input ss, input sclk, input mosi, output miso);
endinterface

// File: rtl/jstk_spi_responder.sv
// SPI slave answering the 5-byte joystick protocol.
// Every SPI pin is oversampled in the clk domain. Each ss falling edge
// captures a 40-bit reply frame from x_pos/y_pos/btn. Byte 0 from the
// master can command the two LED bits.
module jstk_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  jstk_spi_responder_if.slave   spi,
  input  logic [9:0]            x_pos,
  input  logic [9:0]            y_pos,
  input  logic [2:0]            btn,
  output logic [1:0]            led,
  output logic                  frame_done,
  output logic                  frame_err
);

  localparam logic [5:0] FRAME_LEN = 6'(FRAME_BITS);
  localparam logic [5:0] CNT_MAX   = 6'd63;
  localparam logic [5:0] RX_BITS   = 6'd8;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
  logic                   ss_d, sclk_d;
  logic [SYNC_STAGES:0]   fill;
  logic                   ss_s, sclk_s, mosi_s;
  logic                   ss_fall, ss_rise, sclk_rise, sclk_fall;

  logic                   start, finish, rx_step, tx_step;
  logic [39:0]            tx_shift;
  logic [7:0]             rx_shift;
  logic [5:0]             bit_cnt;
  logic                   miso_q;

  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign ss_fall   = ss_d & ~ss_s;
  assign ss_rise   = ~ss_d & ss_s;
  assign sclk_rise = ~sclk_d & sclk_s;
  assign sclk_fall = sclk_d & ~sclk_s;

  assign spi.miso = miso_q;

  // Synchronizer chains, edge-detect copies, and a fill marker that tells when
  // ss_d holds a real pin sample. Without the marker, ss held low through reset
  // would look like a fresh falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_d      <= 1'b1;
      sclk_d    <= 1'b0;
      fill      <= '0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi.ss};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
      ss_d      <= ss_s;
      sclk_d    <= sclk_s;
      fill      <= {fill[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state and datapath strobes. An ss edge takes priority over an sclk edge.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    finish     = 1'b0;
    rx_step    = 1'b0;
    tx_step    = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall && fill[SYNC_STAGES]) begin
          state_next = ACTIVE;
          start      = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_next = IDLE;
          finish     = 1'b1;
        end else if (sclk_rise) begin
          rx_step = 1'b1;
        end else if (sclk_fall) begin
          tx_step = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift registers, bit counter, MISO driver, LED latch and end-of-frame pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_shift   <= '0;
      rx_shift   <= '0;
      bit_cnt    <= '0;
      miso_q     <= 1'b0;
      led        <= 2'b00;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (start) begin
        tx_shift <= {x_pos[7:0], 6'b0, x_pos[9:8], y_pos[7:0], 6'b0, y_pos[9:8], 5'b0, btn};
        miso_q   <= x_pos[7];
        rx_shift <= '0;
        bit_cnt  <= '0;
      end
      if (rx_step) begin
        if (bit_cnt < RX_BITS) rx_shift <= {rx_shift[6:0], mosi_s};
        if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 6'd1;
      end
      if (tx_step) begin
        tx_shift <= {tx_shift[38:0], 1'b0};
        miso_q   <= tx_shift[38];
      end
      if (finish) begin
        miso_q <= 1'b0;
        if (bit_cnt == FRAME_LEN) begin
          frame_done <= 1'b1;
          if (rx_shift[7:2] == 6'b100000) led <= rx_shift[1:0];
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Randomized scoreboard bench for jstk_spi_responder.
// The stimulus side queues the expected MISO bytes and frame outcomes.
// Two monitor processes compare them against what the DUT presents.
module tb_jstk_spi_responder;

  localparam int HALF = 5;

  typedef struct {
    logic       done;
    logic [1:0] led;
  } result_t;

  logic       clk;
  logic       rst;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic [2:0] btn;
  logic [1:0] led;
  logic       frame_done;
  logic       frame_err;

  jstk_spi_responder_if spi ();

  jstk_spi_responder #(.SYNC_STAGES(2), .FRAME_BITS(40)) dut (
    .clk        (clk),
    .rst        (rst),
    .spi        (spi),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .btn        (btn),
    .led        (led),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] byte_q[$];
  result_t    res_q[$];
  logic [1:0] model_led = 2'b00;
  int         mon_bits = 0;
  logic [7:0] mon_shreg = 8'h00;

  // 100 MHz system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // MISO byte monitor: collects one bit per sclk rising edge, as the master samples.
  always @(posedge spi.sclk or negedge spi.ss) begin
    if (spi.sclk == 1'b0) begin
      mon_bits = 0;
    end else if (!spi.ss && rst) begin
      mon_shreg = {mon_shreg[6:0], spi.miso};
      mon_bits++;
      if (mon_bits == 8) begin
        mon_bits = 0;
        checks++;
        if (byte_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL miso_byte got %02h expected none", mon_shreg);
        end else begin
          logic [7:0] exp_b;
          exp_b = byte_q.pop_front();
          if (mon_shreg !== exp_b) begin
            errors++;
            $display("[TB] FAIL miso_byte got %02h expected %02h", mon_shreg, exp_b);
          end
        end
      end
    end
  end

  // Frame outcome monitor: every done/err pulse must match the next queued result.
  always @(negedge clk) begin
    if (rst && (frame_done || frame_err)) begin
      checks++;
      if (res_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL frame_pulse got done=%0b err=%0b expected none", frame_done, frame_err);
      end else begin
        result_t r;
        r = res_q.pop_front();
        if (frame_done !== r.done || frame_err !== !r.done || led !== r.led) begin
          errors++;
          $display("[TB] FAIL frame_end got done=%0b err=%0b led=%0b expected done=%0b err=%0b led=%0b",
                   frame_done, frame_err, led, r.done, !r.done, r.led);
        end
      end
    end
  end

  // One master transaction: nbits sclk cycles with cmd as byte 0.
  // Optionally change x_pos or pulse reset after a given rising edge.
  task automatic apply_stimulus(input int nbits, input logic [7:0] cmd, input int abort_at,
                                input int change_at, input logic [9:0] new_x);
    logic [7:0] exp_bytes[5];
    result_t    r;
    int         nb;
    exp_bytes[0] = 8'(x_pos % 256);
    exp_bytes[1] = 8'(x_pos / 256);
    exp_bytes[2] = 8'(y_pos % 256);
    exp_bytes[3] = 8'(y_pos / 256);
    exp_bytes[4] = 8'(btn);
    nb = (abort_at >= 0) ? abort_at / 8 : nbits / 8;
    for (int i = 0; i < nb; i++) byte_q.push_back((i < 5) ? exp_bytes[i] : 8'h00);
    if (abort_at < 0) begin
      r.done = (nbits == 40);
      if (r.done && (cmd / 4 == 32)) model_led = 2'(cmd % 4);
      r.led = model_led;
      res_q.push_back(r);
    end
    @(negedge clk);
    spi.ss   = 1'b0;
    spi.mosi = cmd[7];
    wait_clk(6);
    for (int b = 0; b < nbits; b++) begin
      spi.sclk = 1'b1;
      if (b + 1 == change_at) x_pos = new_x;
      if (b + 1 == abort_at) begin
        wait_clk(1);
        rst = 1'b0;
        #1;
        check_output("reset_mid_miso", 32'(spi.miso), 32'h0);
        check_output("reset_mid_led", 32'(led), 32'h0);
        check_output("reset_mid_pulses", 32'({frame_done, frame_err}), 32'h0);
        wait_clk(3);
        spi.sclk = 1'b0;
        wait_clk(2);
        rst = 1'b1;
        model_led = 2'b00;
        return;
      end
      wait_clk(HALF);
      spi.sclk = 1'b0;
      if (b + 1 < 8) spi.mosi = cmd[6-b];
      else           spi.mosi = 1'($urandom);
      wait_clk(HALF);
    end
    spi.ss   = 1'b1;
    spi.mosi = 1'b0;
    wait_clk(12);
  endtask

  // Directed test plan followed by randomized frames.
  initial begin
    int lens[8];
    lens = '{0, 8, 24, 40, 40, 40, 48, 72};
    rst      = 1'b0;
    spi.ss   = 1'b1;
    spi.sclk = 1'b0;
    spi.mosi = 1'b0;
    x_pos    = 10'h2A5;
    y_pos    = 10'h13C;
    btn      = 3'b101;
    wait_clk(3);
    check_output("reset_miso", 32'(spi.miso), 32'h0);
    check_output("reset_led", 32'(led), 32'h0);
    check_output("reset_done", 32'(frame_done), 32'h0);
    check_output("reset_err", 32'(frame_err), 32'h0);
    rst = 1'b1;
    wait_clk(8);

    apply_stimulus(40, 8'h81, -1, -1, 10'h0);
    check_output("nominal_led", 32'(led), 32'h1);
    apply_stimulus(40, 8'h43, -1, -1, 10'h0);
    apply_stimulus(24, 8'h82, -1, -1, 10'h0);
    apply_stimulus(40, 8'h81, -1, -1, 10'h0);
    apply_stimulus(40, 8'h83, -1, 5, 10'h3FF);
    apply_stimulus(40, 8'h81, -1, -1, 10'h0);
    apply_stimulus(48, 8'h82, -1, -1, 10'h0);
    check_output("overlong_led", 32'(led), 32'h1);

    x_pos = 10'h2A5;
    apply_stimulus(40, 8'h81, 17, -1, 10'h0);
    wait_clk(10);
    check_output("held_ss_miso", 32'(spi.miso), 32'h0);
    spi.ss = 1'b1;
    wait_clk(12);
    apply_stimulus(40, 8'h82, -1, -1, 10'h0);
    check_output("after_reset_led", 32'(led), 32'h2);

    for (int n = 0; n < 25; n++) begin
      logic [7:0] cmd;
      x_pos = 10'($urandom_range(0, 1023));
      y_pos = 10'($urandom_range(0, 1023));
      btn   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) cmd = 8'h80 + 8'($urandom_range(0, 3));
      else                           cmd = 8'($urandom_range(0, 255));
      apply_stimulus(lens[$urandom_range(0, 7)], cmd, -1, -1, 10'h0);
    end

    for (int i = 0; i < 200 && (byte_q.size() != 0 || res_q.size() != 0); i++) @(negedge clk);
    check_output("bytes_pending", 32'(byte_q.size()), 32'h0);
    check_output("results_pending", 32'(res_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jstk_spi_responder.md
Name: jstk_spi_responder

Overview:
- SPI slave that answers the 5-byte joystick protocol issued by our joystick SPI master (mode 0, MSB first, SS active-low).
- Serves as a bench/loopback model for the joystick master, and as a board-to-board joystick emulator driven from internal position and button registers.
- Runs entirely in the `clk` domain; SPI inputs are oversampled, so no SCLK-clocked logic.

Parameters:
- SYNC_STAGES, 2, number of flip-flop synchronizer stages on spi_ss, spi_sclk and spi_mosi (minimum 2).
- FRAME_BITS, 40, number of SCLK rising edges that make a valid frame (5 bytes).

Ports:
- clk  input  1  system clock (100 MHz).
- rst  input  1  asynchronous, active-low reset.
- spi_ss  input  1  chip select from master, active-low.
- spi_sclk  input  1  SPI clock from master, idle low.
- spi_mosi  input  1  master-to-slave data.
- spi_miso  output  1  slave-to-master data.
- x_pos  input  10  joystick X value to report.
- y_pos  input  10  joystick Y value to report.
- btn  input  3  button states {btn2, btn1, btn0}.
- led  output  2  LED bits commanded by the master.
- frame_done  output  1  one-cycle pulse when a valid frame ends.
- frame_err  output  1  one-cycle pulse when a frame ends with the wrong bit count.

Behaviour:
- Reset (rst low, asynchronous):
  - spi_miso=0, led=2'b00, frame_done=0, frame_err=0.
  - Bit counter=0, shift registers=0, synchronizers=idle values (ss=1, sclk=0, mosi=0), state=IDLE.
- Input synchronization and edge detection:
  - Each SPI input passes through SYNC_STAGES flops, plus one extra registered copy for edge detection.
  - Events are the synchronized falling/rising edges of ss and sclk.
  - Event latency is SYNC_STAGES+1 clk cycles after the pin changes.
  - SCLK period must be at least 8 clk cycles; behaviour above that rate is undefined.
- State machine: IDLE, ACTIVE.
- IDLE -> ACTIVE on the ss falling event:
  - Snapshot tx frame, 40 bits, MSB first: byte0=x_pos[7:0], byte1={6'b0,x_pos[9:8]}, byte2=y_pos[7:0], byte3={6'b0,y_pos[9:8]}, byte4={5'b0,btn}.
  - Clear the bit counter and rx register.
  - Drive spi_miso with tx bit 39 in the same cycle.
- In ACTIVE:
  - sclk rising event: shift synchronized mosi into the 8-bit rx register. Once the counter reaches 8, rx is frozen (holds byte0). The 6-bit bit counter increments and saturates at 63.
  - sclk falling event: shift tx left and drive the next bit on spi_miso. After bit 0 has been shifted out, spi_miso=0.
  - Changes on x_pos, y_pos or btn during ACTIVE do not affect the frame in flight.
- ACTIVE -> IDLE on the ss rising event:
  - If counter==FRAME_BITS: frame_done=1 for one cycle. If rx[7:2]==6'b100000, led<=rx[1:0]; otherwise led is unchanged.
  - If counter!=FRAME_BITS (including 0, or more than 40): frame_err=1 for one cycle and led is unchanged.
  - spi_miso returns to 0.
- Ignored events:
  - sclk events while in IDLE.
  - A ss falling event while already ACTIVE cannot occur (edges alternate).
- Simultaneous ss rising and sclk edge events in the same cycle: the ss event wins and the sclk edge is dropped.
- Reset mid-frame: immediate return to IDLE with reset values and no pulse. The next frame starts only on a fresh ss falling event, so a held-low ss after reset release gives no frame until ss goes high then low.
- frame_done and frame_err are never asserted in the same cycle.

Test Plan:
- Nominal read: x_pos=10'h2A5, y_pos=10'h13C, btn=3'b101; master sends 0x81,0,0,0,0 at SCLK=clk/10.
  - Required MISO bytes: 0xA5, 0x02, 0x3C, 0x01, 0x05.
  - frame_done pulses once after ss high; led=2'b01.
- Bad command: master sends byte0=0x43 in a full 40-bit frame -> frame_done=1, led holds its prior value 2'b01.
- Short frame: ss released after 24 bits -> frame_err pulses once, frame_done stays 0, led unchanged. The next full frame returns correct data.
- Snapshot stability: change x_pos from 10'h2A5 to 10'h3FF at bit 5 -> bytes 0/1 still read 0xA5/0x02. The next frame reads 0xFF/0x03.
- Reset mid-frame: drop rst at bit 17 -> spi_miso=0 and led=0 immediately, no pulses. After rst rises and ss toggles high then low, a full frame returns correct data.
- Overlong frame: 48 SCLK edges -> bits 41-48 on MISO are 0, frame_err pulses, led unchanged.
